// File: rtl/cluster_axi2per_bridge.sv
// cluster_axi2per_bridge
//   AXI4 slave to PULP peripheral-bus master. Each AXI burst is split into
//   single-beat peripheral transactions (req/gnt, then r_valid). One burst is
//   in flight at a time, and its responses carry the ID of the burst.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   aw_* / ar_*                AXI write/read address channels
//   w_*                        AXI write data channel
//   b_*                        AXI write response channel
//   r_*                        AXI read data channel
//   per_req_o .. per_be_o      peripheral request side
//   per_gnt_i, per_r_*         peripheral grant and response side
//
// State | meaning
//   IDLE    | arbitrate AW/AR, latch burst attributes
//   RD_REQ  | read request on peripheral bus, waiting for grant
//   RD_WAIT | waiting for the read response
//   RD_OUT  | presenting one R beat until it is taken
//   WR_DATA | waiting for one W beat
//   WR_REQ  | write request on peripheral bus, waiting for grant
//   WR_WAIT | waiting for the write response
//   WR_RESP | presenting B until it is taken
module cluster_axi2per_bridge #(
  parameter int AXI_ADDR_WIDTH = 48,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int PER_ADDR_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic [2:0]                  aw_size_i,
  input  logic [1:0]                  aw_burst_i,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  input  logic [2:0]                  ar_size_i,
  input  logic [1:0]                  ar_burst_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic                        per_req_o,
  input  logic                        per_gnt_i,
  output logic [PER_ADDR_WIDTH-1:0]   per_add_o,
  output logic                        per_wen_o,
  output logic [AXI_DATA_WIDTH-1:0]   per_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] per_be_o,
  input  logic                        per_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   per_r_rdata_i,
  input  logic                        per_r_opc_i
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic                      prio_q, prio_d;   // 1 = write wins a tie
  logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [2:0]                size_q, size_d;
  logic [1:0]                burst_q, burst_d;
  logic [7:0]                beat_q, beat_d;
  logic                      err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      rlast_q, rlast_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      wlast_q, wlast_d;

  logic                      aw_sel, ar_sel;
  logic [AXI_ADDR_WIDTH-1:0] addr_step, addr_next;

  assign aw_sel = aw_valid_i && (!ar_valid_i || prio_q);
  assign ar_sel = ar_valid_i && !aw_sel;

  // WRAP bursts advance like INCR; only FIXED holds the address.
  assign addr_step = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + addr_step;

  assign per_add_o   = addr_q[PER_ADDR_WIDTH-1:0];
  assign per_wdata_o = wdata_q;
  assign r_id_o      = id_q;
  assign r_data_o    = rdata_q;
  assign r_resp_o    = rresp_q;
  assign r_last_o    = rlast_q;
  assign b_id_o      = id_q;
  assign b_resp_o    = err_q ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    per_req_o  = 1'b0;
    per_wen_o  = 1'b0;
    per_be_o   = '0;

    unique case (state_q)
      IDLE: begin
        aw_ready_o = aw_sel;
        ar_ready_o = ar_sel;
        if (aw_valid_i && ar_valid_i) prio_d = !prio_q;
        if (aw_sel) begin
          id_d    = aw_id_i;
          addr_d  = aw_addr_i;
          len_d   = aw_len_i;
          size_d  = aw_size_i;
          burst_d = aw_burst_i;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end else if (ar_sel) begin
          id_d    = ar_id_i;
          addr_d  = ar_addr_i;
          len_d   = ar_len_i;
          size_d  = ar_size_i;
          burst_d = ar_burst_i;
          beat_d  = '0;
          err_d   = 1'b0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        per_req_o = 1'b1;
        per_wen_o = 1'b1;
        per_be_o  = '1;
        if (per_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (per_r_valid_i) begin
          rdata_d = per_r_rdata_i;
          rresp_d = per_r_opc_i ? RESP_SLVERR : RESP_OKAY;
          rlast_d = (beat_q == len_q);
          state_d = RD_OUT;
        end
      end
      RD_OUT: begin
        r_valid_o = 1'b1;
        if (r_ready_i) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          wdata_d = w_data_i;
          wstrb_d = w_strb_i;
          wlast_d = w_last_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        per_req_o = 1'b1;
        per_wen_o = 1'b0;
        per_be_o  = wstrb_q;
        if (per_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (per_r_valid_i) begin
          // A W beat flagged last before len is reached truncates the burst
          // and is reported as a slave error.
          err_d = err_q || per_r_opc_i || (wlast_q && (beat_q != len_q));
          if ((beat_q == len_q) || wlast_q) begin
            state_d = WR_RESP;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = WR_DATA;
          end
        end
      end
      WR_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wlast_q <= wlast_d;
    end
  end

endmodule

// File: tb/tb_cluster_axi2per_bridge.sv
// Scoreboard bench for cluster_axi2per_bridge: stimulus pushes expected
// peripheral requests, R beats and B responses; a monitor compares them as
// the bridge presents them.
module tb_cluster_axi2per_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
  logic [5:0]  aw_id_i, ar_id_i;
  logic [47:0] aw_addr_i, ar_addr_i;
  logic [7:0]  aw_len_i, ar_len_i;
  logic [2:0]  aw_size_i, ar_size_i;
  logic [1:0]  aw_burst_i, ar_burst_i;
  logic        w_valid_i, w_ready_o, w_last_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        b_valid_o, b_ready_i;
  logic [5:0]  b_id_o, r_id_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        r_valid_o, r_ready_i, r_last_o;
  logic [63:0] r_data_o;
  logic        per_req_o, per_gnt_i, per_wen_o, per_r_valid_i, per_r_opc_i;
  logic [31:0] per_add_o;
  logic [63:0] per_wdata_o, per_r_rdata_i;
  logic [7:0]  per_be_o;

  cluster_axi2per_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .b_resp_o(b_resp_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .per_req_o(per_req_o), .per_gnt_i(per_gnt_i), .per_add_o(per_add_o),
    .per_wen_o(per_wen_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i),
    .per_r_opc_i(per_r_opc_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] add; logic wen; logic [7:0] be; logic [63:0] wdata; } per_exp_t;
  typedef struct { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [63:0] data; logic opc; } rsp_t;

  per_exp_t per_exp_q[$];
  r_exp_t   r_exp_q[$];
  b_exp_t   b_exp_q[$];
  rsp_t     rsp_q[$];

  int vecs = 0;
  int errs = 0;
  int rsp_delay = 0;
  int rh_count = 0;
  int stall_at = -1;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [5:0] id, input int b);
    return {26'h0, id, 32'hA5A5_0000 + b};
  endfunction

  function automatic logic [7:0] strb_of(input int b);
    case (b % 4)
      0: return 8'hFF;
      1: return 8'h0F;
      2: return 8'hF0;
      default: return 8'h81;
    endcase
  endfunction

  // ---------------- peripheral slave model ----------------
  int  pend = 0;
  int  dly = 0;
  rsp_t rsp_cur;
  always begin
    @(posedge clk_i);
    #2;
    if (!rst_ni) begin
      per_gnt_i = 1'b0;
      per_r_valid_i = 1'b0;
      pend = 0;
      rsp_q.delete();
    end else begin
      per_r_valid_i = 1'b0;
      if (pend != 0) begin
        if (dly == 0) begin
          if (rsp_q.size() > 0) rsp_cur = rsp_q.pop_front();
          else begin rsp_cur.data = '0; rsp_cur.opc = 1'b0; end
          per_r_rdata_i = rsp_cur.data;
          per_r_opc_i   = rsp_cur.opc;
          per_r_valid_i = 1'b1;
          pend = 0;
        end else begin
          dly--;
        end
      end
      if (per_req_o && pend == 0) begin
        per_gnt_i = 1'b1;
        pend = 1;
        dly = rsp_delay;
      end else begin
        per_gnt_i = 1'b0;
      end
    end
  end

  // ---------------- R back-pressure ----------------
  always begin
    @(posedge clk_i);
    #2;
    if (r_valid_o && rh_count == stall_at && stall_cnt < 5) begin
      r_ready_i = 1'b0;
      stall_cnt++;
    end else begin
      r_ready_i = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  per_exp_t pe;
  r_exp_t   re;
  b_exp_t   be;
  logic        r_stall = 1'b0;
  logic [63:0] held_data;
  logic [8:0]  held_meta;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      r_stall = 1'b0;
    end else begin
      if (per_req_o && per_gnt_i) begin
        if (per_exp_q.size() == 0) begin
          chk("per_unexpected_req", {32'h0, per_add_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          pe = per_exp_q.pop_front();
          chk("per_add", {32'h0, per_add_o}, {32'h0, pe.add});
          chk("per_wen", {63'h0, per_wen_o}, {63'h0, pe.wen});
          chk("per_be", {56'h0, per_be_o}, {56'h0, pe.be});
          if (!pe.wen) chk("per_wdata", per_wdata_o, pe.wdata);
        end
      end
      if (r_valid_o) begin
        chk("per_req_during_r", {63'h0, per_req_o}, 64'h0);
        if (r_stall) begin
          chk("r_data_stable", r_data_o, held_data);
          chk("r_meta_stable", {55'h0, r_id_o, r_resp_o, r_last_o}, {55'h0, held_meta});
        end
        if (r_ready_i) begin
          r_stall = 1'b0;
          rh_count++;
          if (r_exp_q.size() == 0) begin
            chk("r_unexpected", r_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            re = r_exp_q.pop_front();
            chk("r_id", {58'h0, r_id_o}, {58'h0, re.id});
            chk("r_data", r_data_o, re.data);
            chk("r_resp", {62'h0, r_resp_o}, {62'h0, re.resp});
            chk("r_last", {63'h0, r_last_o}, {63'h0, re.last});
          end
        end else begin
          r_stall = 1'b1;
          held_data = r_data_o;
          held_meta = {r_id_o, r_resp_o, r_last_o};
        end
      end
      if (b_valid_o && b_ready_i) begin
        if (b_exp_q.size() == 0) begin
          chk("b_unexpected", {58'h0, b_id_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          be = b_exp_q.pop_front();
          chk("b_id", {58'h0, b_id_o}, {58'h0, be.id});
          chk("b_resp", {62'h0, b_resp_o}, {62'h0, be.resp});
        end
      end
    end
  end

  // ---------------- expectation builders ----------------
  task automatic exp_read(input logic [5:0] id, input logic [47:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [63:0] base, input logic [7:0] opc_mask);
    logic [47:0] a = addr;
    for (int b = 0; b <= len; b++) begin
      per_exp_q.push_back('{add: a[31:0], wen: 1'b1, be: 8'hFF, wdata: 64'h0});
      rsp_q.push_back('{data: base + 64'(b), opc: opc_mask[b]});
      r_exp_q.push_back('{id: id, data: base + 64'(b),
                          resp: opc_mask[b] ? 2'b10 : 2'b00, last: (b == len)});
      if (burst != 2'b00) a = a + (48'd1 << size);
    end
  endtask

  task automatic exp_write(input logic [5:0] id, input logic [47:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int nbeats, input logic [7:0] opc_mask);
    logic [47:0] a = addr;
    logic err = (nbeats < len + 1);
    for (int b = 0; b < nbeats; b++) begin
      per_exp_q.push_back('{add: a[31:0], wen: 1'b0, be: strb_of(b), wdata: data_of(id, b)});
      rsp_q.push_back('{data: 64'h0, opc: opc_mask[b]});
      if (opc_mask[b]) err = 1'b1;
      if (burst != 2'b00) a = a + (48'd1 << size);
    end
    b_exp_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
  endtask

  // ---------------- drivers (called at posedge+2) ----------------
  task automatic send_aw(input logic [5:0] id, input logic [47:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = 8'(len); aw_size_i = size;
    aw_burst_i = burst; aw_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (aw_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("aw_timeout", 64'h0, 64'h1);
    @(posedge clk_i); #2;
    aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [5:0] id, input logic [47:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = 8'(len); ar_size_i = size;
    ar_burst_i = burst; ar_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (ar_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("ar_timeout", 64'h0, 64'h1);
    @(posedge clk_i); #2;
    ar_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    bit ok = 0;
    w_data_i = data; w_strb_i = strb; w_last_i = last; w_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (w_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("w_timeout", 64'h0, 64'h1);
    @(posedge clk_i); #2;
    w_valid_i = 1'b0;
  endtask

  task automatic drive_write(input logic [5:0] id, input logic [47:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    fork
      send_aw(id, addr, len, size, burst);
      begin
        for (int b = 0; b < nbeats; b++) send_w(data_of(id, b), strb_of(b), b == nbeats - 1);
      end
    join
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (per_exp_q.size() == 0 && r_exp_q.size() == 0 && b_exp_q.size() == 0) break;
    end
    chk("drain", 64'(per_exp_q.size() + r_exp_q.size() + b_exp_q.size()), 64'h0);
    @(posedge clk_i); #2;
  endtask

  initial begin
    rst_ni = 1'b0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    b_ready_i = 1'b1; r_ready_i = 1'b1;
    per_gnt_i = 0; per_r_valid_i = 0; per_r_rdata_i = 0; per_r_opc_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_per_req", {63'h0, per_req_o}, 64'h0);
    chk("rst_r_valid", {63'h0, r_valid_o}, 64'h0);
    chk("rst_b_valid", {63'h0, b_valid_o}, 64'h0);
    chk("rst_w_ready", {63'h0, w_ready_o}, 64'h0);
    chk("rst_per_add", {32'h0, per_add_o}, 64'h0);
    @(posedge clk_i); #4;
    rst_ni = 1'b1;
    @(posedge clk_i); #2;

    // single-beat read
    exp_read(6'd5, 48'h0000_1020_0000, 0, 3'd3, 2'b01, 64'h0000_0000_DEAD_BEEF, 8'h00);
    send_ar(6'd5, 48'h0000_1020_0000, 0, 3'd3, 2'b01);
    wait_done();

    // 4-beat INCR write
    exp_write(6'd3, 48'h0000_1020_0100, 3, 3'd3, 2'b01, 4, 8'h00);
    drive_write(6'd3, 48'h0000_1020_0100, 3, 3'd3, 2'b01, 4);
    wait_done();

    // simultaneous AW/AR: write first, then read first next time
    exp_write(6'd10, 48'h0001_1020_0200, 1, 3'd3, 2'b01, 2, 8'h00);
    exp_read(6'd11, 48'h0000_1020_0300, 1, 3'd3, 2'b01, 64'h1111_0000_0000_0000, 8'h00);
    fork
      drive_write(6'd10, 48'h0001_1020_0200, 1, 3'd3, 2'b01, 2);
      send_ar(6'd11, 48'h0000_1020_0300, 1, 3'd3, 2'b01);
    join
    wait_done();
    exp_read(6'd13, 48'h0000_1020_0500, 0, 3'd3, 2'b01, 64'h2222_0000_0000_0000, 8'h00);
    exp_write(6'd12, 48'h0000_1020_0400, 0, 3'd3, 2'b01, 1, 8'h00);
    fork
      drive_write(6'd12, 48'h0000_1020_0400, 0, 3'd3, 2'b01, 1);
      send_ar(6'd13, 48'h0000_1020_0500, 0, 3'd3, 2'b01);
    join
    wait_done();

    // FIXED read with R stalled on beat 1
    stall_cnt = 0;
    stall_at = rh_count + 1;
    exp_read(6'd20, 48'h0000_1020_0600, 2, 3'd3, 2'b00, 64'h3333_0000_0000_0000, 8'h00);
    send_ar(6'd20, 48'h0000_1020_0600, 2, 3'd3, 2'b00);
    wait_done();
    chk("stall_cycles", 64'(stall_cnt), 64'd5);
    stall_at = -1;

    // error responses
    exp_write(6'd21, 48'h0000_1020_0800, 1, 3'd3, 2'b01, 2, 8'h01);
    drive_write(6'd21, 48'h0000_1020_0800, 1, 3'd3, 2'b01, 2);
    wait_done();
    exp_read(6'd22, 48'h0000_1020_0900, 1, 3'd3, 2'b01, 64'h4444_0000_0000_0000, 8'h02);
    send_ar(6'd22, 48'h0000_1020_0900, 1, 3'd3, 2'b01);
    wait_done();

    // early w_last: len=3 but last on beat 1
    exp_write(6'd23, 48'h0000_1020_0A00, 3, 3'd3, 2'b01, 2, 8'h00);
    drive_write(6'd23, 48'h0000_1020_0A00, 3, 3'd3, 2'b01, 2);
    wait_done();

    // WRAP behaves as INCR, size 2
    exp_read(6'd24, 48'h0000_1020_0700, 1, 3'd2, 2'b10, 64'h5555_0000_0000_0000, 8'h00);
    send_ar(6'd24, 48'h0000_1020_0700, 1, 3'd2, 2'b10);
    wait_done();

    // address wraps modulo 2^48
    exp_read(6'd25, 48'hFFFF_FFFF_FFF8, 1, 3'd3, 2'b01, 64'h6666_0000_0000_0000, 8'h00);
    send_ar(6'd25, 48'hFFFF_FFFF_FFF8, 1, 3'd3, 2'b01);
    wait_done();

    // async reset during RD_WAIT; the aborted read produces no R
    rsp_delay = 4;
    per_exp_q.push_back('{add: 32'h1020_0040, wen: 1'b1, be: 8'hFF, wdata: 64'h0});
    send_ar(6'd7, 48'h0000_1020_0040, 0, 3'd3, 2'b01);
    begin
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_i);
        if (per_req_o && per_gnt_i) begin seen = 1; break; end
      end
      if (!seen) chk("rst_test_gnt_timeout", 64'h0, 64'h1);
    end
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_per_req", {63'h0, per_req_o}, 64'h0);
    chk("arst_r_valid", {63'h0, r_valid_o}, 64'h0);
    chk("arst_per_add", {32'h0, per_add_o}, 64'h0);
    chk("arst_r_id", {58'h0, r_id_o}, 64'h0);
    repeat (2) @(posedge clk_i);
    #4;
    rst_ni = 1'b1;
    rsp_delay = 0;
    @(posedge clk_i); #2;
    exp_read(6'd9, 48'h0000_1020_0080, 0, 3'd3, 2'b01, 64'h7777_0000_0000_0009, 8'h00);
    send_ar(6'd9, 48'h0000_1020_0080, 0, 3'd3, 2'b01);
    wait_done();

    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cluster_axi2per_bridge.md
Name: cluster_axi2per_bridge

Overview:
- Downstream of the cluster AXI crossbar's peripheral master port (crossbar master index 1, address window base+0x0020_0000..base+0x0040_0000).
- Converts AXI4 bursts into single-beat PULP peripheral-bus transactions (req/gnt, then r_valid response) to the cluster peripheral interconnect.
- Serializes reads and writes: one burst in flight; responses carry the AXI ID of the burst they answer.

Parameters:
- AXI_ADDR_WIDTH, 48, AXI address width
- AXI_DATA_WIDTH, 64, AXI and peripheral data width (equal; no width conversion)
- AXI_ID_WIDTH, 6, ID width; matches crossbar output ID width
- PER_ADDR_WIDTH, 32, peripheral address width; low bits of the AXI address

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- aw_valid_i, ar_valid_i  in  1  address-channel valid (write, read)
- aw_ready_o, ar_ready_o  out  1  address-channel ready
- aw_id_i, ar_id_i  in  AXI_ID_WIDTH  transaction ID
- aw_addr_i, ar_addr_i  in  AXI_ADDR_WIDTH  start address
- aw_len_i, ar_len_i  in  8  beats minus 1
- aw_size_i, ar_size_i  in  3  log2 bytes per beat
- aw_burst_i, ar_burst_i  in  2  burst type
- w_valid_i / w_ready_o  in/out  1  W handshake
- w_data_i  in  AXI_DATA_WIDTH  write data
- w_strb_i  in  AXI_DATA_WIDTH/8  byte strobes
- w_last_i  in  1  last W beat
- b_valid_o / b_ready_i  out/in  1  B handshake
- b_id_o  out  AXI_ID_WIDTH  ID of completed write
- b_resp_o  out  2  write response
- r_valid_o / r_ready_i  out/in  1  R handshake
- r_id_o  out  AXI_ID_WIDTH  ID of read burst
- r_data_o  out  AXI_DATA_WIDTH  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last R beat
- per_req_o / per_gnt_i  out/in  1  peripheral request/grant
- per_add_o  out  PER_ADDR_WIDTH  beat address
- per_wen_o  out  1  1 = read, 0 = write
- per_wdata_o  out  AXI_DATA_WIDTH  write data
- per_be_o  out  AXI_DATA_WIDTH/8  byte enables
- per_r_valid_i  in  1  response valid
- per_r_rdata_i  in  AXI_DATA_WIDTH  read data
- per_r_opc_i  in  1  1 = error

Behaviour:
- Reset: state IDLE; all valid/ready/req outputs 0; data/ID/resp/address registers 0; priority = write-first.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ, WR_WAIT, WR_RESP.
- IDLE arbitration:
  - Only AW valid -> accept write; only AR valid -> accept read.
  - Both valid -> accept the one selected by the priority bit, then flip the bit.
  - aw_ready_o/ar_ready_o assert combinationally in IDLE only, for the selected channel.
  - On accept, latch id, addr, len, size, burst; clear the beat counter and the sticky error.
- Beat address:
  - INCR or WRAP (WRAP is treated as INCR): addr += 1<<size after each beat.
  - FIXED: addr unchanged.
  - per_add_o = addr[PER_ADDR_WIDTH-1:0]; arithmetic is modulo 2^AXI_ADDR_WIDTH.
- Read path:
  - RD_REQ: per_req_o=1, per_wen_o=1, per_be_o all ones; held with stable address until per_gnt_i; then RD_WAIT.
  - RD_WAIT: on per_r_valid_i, register rdata; resp = SLVERR(2'b10) if opc else OKAY; r_last = (beat==len); go to RD_OUT.
  - RD_OUT: r_valid_o=1, payload stable until r_ready_i. On handshake: if last -> IDLE, else beat++, address advance, RD_REQ.
  - Minimum per-beat latency: gnt in cycle N, r_valid in N+1, R valid in N+2.
- Write path:
  - WR_DATA: w_ready_o=1; on W handshake, register data/strb/last; go to WR_REQ.
  - WR_REQ: per_req_o=1, per_wen_o=0, per_wdata_o/per_be_o from registers; held until per_gnt_i.
  - WR_WAIT: on per_r_valid_i, OR opc into the sticky error. Then:
    - beat==len (or registered w_last) -> WR_RESP;
    - otherwise beat++, address advance, WR_DATA.
  - w_last_i is authoritative: early w_last ends the burst and forces SLVERR.
  - WR_RESP: b_valid_o=1, b_id_o = latched ID, b_resp_o = SLVERR if sticky error else OKAY; held until b_ready_i, then IDLE.
- Peripheral rules:
  - One outstanding request at a time.
  - per_r_valid_i arriving outside RD_WAIT/WR_WAIT is ignored.
  - per_gnt_i without per_req_o is ignored.
- No AW/AR acceptance while a burst is active; W beats are never accepted outside WR_DATA.
- Async reset mid-burst: immediate return to reset values; in-flight burst dropped, no B/R emitted.

Test Plan:
- AR id=5, addr=0x1020_0000, len=0, size=3; gnt immediate, r_valid next cycle, rdata=0xDEAD_BEEF -> per_add=0x1020_0000, wen=1; one R: id=5, data=0xDEAD_BEEF, OKAY, last=1.
- AW id=3, addr=0x1020_0100, len=3, INCR, size=3 + 4 W beats -> per_add 0x...100/108/110/118, wen=0, strobes passed through; single B id=3, OKAY after 4th response.
- AW and AR valid in same cycle from IDLE, twice -> first write then read; second pair read first (alternation).
- Read len=2, FIXED, r_ready held low 5 cycles on beat 1 -> all 3 per_add equal; no second per_req until R handshake; R payload stable while stalled.
- Write len=1 with per_r_opc=1 on beat 0 -> B resp=2'b10; read with opc=1 on beat 1 only -> R resps OKAY, SLVERR.
- Assert rst_ni low during RD_WAIT -> outputs zero asynchronously; after release, new AR completes normally.
